// File: rtl/mem_lsu.sv
// mem_lsu: data-memory load/store unit sitting between EX_MEM and a simple
// single-outstanding-request data bus.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses take the access_fault path
//   undefined : address low bits below the access size are cleared, so every
//               access is forced to natural alignment and never faults
//
// Bus handshake: dmem_req is a level request. Once raised, dmem_req, dmem_we,
// dmem_addr, dmem_wdata and dmem_be stay constant until the cycle in which
// dmem_ack is sampled high. That cycle completes the transfer and dmem_rdata is
// valid only there. dmem_ack is ignored whenever no request is outstanding.
module mem_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [2:0]  funct3_in,
  input  logic        MemW_in,
  input  logic        memRead_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        access_fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_data_q, load_data_d;

  logic        access;
  logic        f3_legal;
  logic        misaligned;
  logic        access_ok;
  logic [1:0]  lane_off;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] rdata_shift;
  logic [31:0] load_ext;
  logic        stall_c;
  logic        fault_c;

  // Decode the incoming EX_MEM access: legality, lane offset, byte enables and
  // lane-replicated store data. A store wins when both request lines are high.
  always_comb begin
    access     = MemW_in | memRead_in;
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    lane_off   = 2'b00;
    be_new     = 4'b1111;
    wdata_new  = wdata_in;

    case (funct3_in)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~MemW_in;
      default:                f3_legal = 1'b0;
    endcase

`ifdef MISALIGN_TRAP_EN
    misaligned = ((funct3_in[1:0] == 2'b01) && addr_in[0]) ||
                 ((funct3_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif

    case (funct3_in[1:0])
      2'b00: begin
        lane_off  = addr_in[1:0];
        be_new    = 4'b0001 << addr_in[1:0];
        wdata_new = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        lane_off  = {addr_in[1], 1'b0};
        be_new    = 4'b0011 << {addr_in[1], 1'b0};
        wdata_new = {2{wdata_in[15:0]}};
      end
      default: begin
        lane_off  = 2'b00;
        be_new    = 4'b1111;
        wdata_new = wdata_in;
      end
    endcase

    access_ok = access & f3_legal & ~misaligned;
  end

  // Align the returned word to the latched lane and extend it by access type.
  always_comb begin
    rdata_shift = dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_ext = {24'h000000, rdata_shift[7:0]};
      3'b101:  load_ext = {16'h0000, rdata_shift[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Next-state and datapath-capture logic for the IDLE -> REQ -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    f3_d        = f3_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    stall_c     = 1'b0;
    fault_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (access_ok) begin
          addr_d  = {addr_in[31:2], 2'b00};
          wdata_d = wdata_new;
          be_d    = be_new;
          we_d    = MemW_in;
          f3_d    = funct3_in;
          off_d   = lane_off;
          req_d   = 1'b1;
          stall_c = 1'b1;
          state_d = ST_REQ;
        end else if (access) begin
          // Illegal or trapped access: flag it, let the pipeline move on.
          fault_c = 1'b1;
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (dmem_ack) begin
          req_d = 1'b0;
          if (!we_q) begin
            load_data_d = load_ext;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Stall released for exactly this cycle so the pipeline steps once.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign load_data    = load_data_q;
  // Combinational outputs are forced low while reset is held.
  assign stall        = stall_c & reset;
  assign access_fault = fault_c & reset;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu. A transaction-level model predicts
// the bus word and load result from access size/sign rules; a negedge compare
// process checks every cycle, and literal per-test values pin the model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [2:0]  funct3_in;
  logic        MemW_in;
  logic        memRead_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        stall;
  logic        access_fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Model of the unit: phase 0 idle, 1 waiting on the bus, 2 completion cycle.
  int          m_phase   = 0;
  logic        m_req     = 1'b0;
  logic        m_we      = 1'b0;
  logic [31:0] m_addr    = 32'h0;
  logic [31:0] m_wdata   = 32'h0;
  logic [3:0]  m_be      = 4'h0;
  logic [31:0] m_load    = 32'h0;
  int          m_off     = 0;
  int          m_nbytes  = 4;
  logic        m_signed  = 1'b0;

  mem_lsu dut (
    .clk          (clk),
    .reset        (reset),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .funct3_in    (funct3_in),
    .MemW_in      (MemW_in),
    .memRead_in   (memRead_in),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .load_data    (load_data),
    .stall        (stall),
    .access_fault (access_fault)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit tb_legal(input logic st, input logic ld, input logic [2:0] f3,
                                  input logic [31:0] a);
    if (!(st || ld)) return 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (st && f3 >= 3'd4) return 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (f3[1:0] == 2'd1 && (a % 2) != 0) return 1'b0;
    if (f3 == 3'd2 && (a % 4) != 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Model update on the same edges as the design.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0;
      m_req   = 1'b0;
      m_we    = 1'b0;
      m_addr  = 32'h0;
      m_wdata = 32'h0;
      m_be    = 4'h0;
      m_load  = 32'h0;
    end else begin
      case (m_phase)
        0: begin
          if (tb_legal(MemW_in, memRead_in, funct3_in, addr_in)) begin
            m_nbytes = 1 << funct3_in[1:0];
            m_off    = int'(addr_in % 4) - (int'(addr_in % 4) % m_nbytes);
            m_signed = (funct3_in < 3'd4);
            m_addr   = addr_in - (addr_in % 4);
            m_be     = 4'(((1 << m_nbytes) - 1) << m_off);
            if (m_nbytes == 1)      m_wdata = (wdata_in & 32'hFF) * 32'h01010101;
            else if (m_nbytes == 2) m_wdata = (wdata_in & 32'hFFFF) * 32'h00010001;
            else                    m_wdata = wdata_in;
            m_we    = MemW_in;
            m_req   = 1'b1;
            m_phase = 1;
          end
        end
        1: begin
          if (dmem_ack) begin
            m_req = 1'b0;
            if (!m_we) begin
              logic [31:0] v;
              v = dmem_rdata >> (8 * m_off);
              if (m_nbytes == 1) begin
                v = v & 32'hFF;
                if (m_signed && v >= 32'd128) v = v - 32'd256;
              end else if (m_nbytes == 2) begin
                v = v & 32'hFFFF;
                if (m_signed && v >= 32'd32768) v = v - 32'd65536;
              end
              m_load = v;
            end
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic acc_now;
    logic legal_now;
    acc_now   = MemW_in | memRead_in;
    legal_now = tb_legal(MemW_in, memRead_in, funct3_in, addr_in);
    check("stall", stall, reset && ((m_phase == 0 && legal_now) || m_phase == 1));
    check("access_fault", access_fault, reset && m_phase == 0 && acc_now && !legal_now);
    check("dmem_req", dmem_req, m_req);
    check("load_data", load_data, m_load);
    if (m_req) begin
      check("dmem_we", dmem_we, m_we);
      check("dmem_addr", dmem_addr, m_addr);
      check("dmem_be", dmem_be, m_be);
      check("dmem_wdata", dmem_wdata, m_wdata);
    end
    if (reset && m_phase == 2) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        check("done_load_data", load_data, exp_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    MemW_in    = 1'b0;
    memRead_in = 1'b0;
    funct3_in  = 3'b000;
    addr_in    = 32'h0;
    wdata_in   = 32'h0;
  endtask

  // Driver: one full access. Called at posedge+1 with the unit idle; the
  // request is held (pipeline frozen) until the completion cycle.
  task automatic do_acc(input logic st, input logic ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int waits,
                        input logic [31:0] rd, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_load, input int e_stall);
    int stall_cnt;
    stall_cnt  = 0;
    MemW_in    = st;
    memRead_in = ld;
    funct3_in  = f3;
    addr_in    = a;
    wdata_in   = wd;
    dmem_ack   = 1'b0;
    @(negedge clk);
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      dmem_ack   = (i == waits);
      dmem_rdata = rd;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (i == 0) begin
        check("lit_req", dmem_req, 1'b1);
        check("lit_addr", dmem_addr, e_addr);
        check("lit_be", dmem_be, e_be);
        check("lit_we", dmem_we, st);
        if (st) check("lit_wdata", dmem_wdata, e_wdata);
      end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    idle_inputs();
    exp_q.push_back(e_load);
    @(negedge clk);
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    check("lit_stall_cycles", stall_cnt, e_stall);
  endtask

  // Driver: an access that must fault without touching the bus.
  task automatic do_fault(input logic st, input logic ld, input logic [2:0] f3,
                          input logic [31:0] a);
    MemW_in    = st;
    memRead_in = ld;
    funct3_in  = f3;
    addr_in    = a;
    wdata_in   = 32'h12345678;
    @(negedge clk);
    check("lit_fault_pulse", access_fault, 1'b1);
    check("lit_fault_stall", stall, 1'b0);
    check("lit_fault_req", dmem_req, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("lit_fault_clear", access_fault, 1'b0);
    check("lit_fault_noreq", dmem_req, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    idle_inputs();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", dmem_req, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_load", load_data, 32'h0);
    check("rst_fault", access_fault, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    // SW, ack in the 2nd REQ cycle: stall over IDLE + two REQ cycles.
    do_acc(1, 0, 3'b010, 32'h104, 32'hDEADBEEF, 1, 32'h0, 32'h104, 4'b1111, 32'hDEADBEEF, 32'h0, 3);
    // LB / LBU from the top byte lane.
    do_acc(0, 1, 3'b000, 32'h203, 32'h0, 0, 32'h80FFFF7F, 32'h200, 4'b1000, 32'h0, 32'hFFFFFF80, 2);
    do_acc(0, 1, 3'b100, 32'h203, 32'h0, 0, 32'h80FFFF7F, 32'h200, 4'b1000, 32'h0, 32'h00000080, 2);
    // SH upper half, halfword replicated; load_data untouched.
    do_acc(1, 0, 3'b001, 32'h302, 32'h0000ABCD, 0, 32'h0, 32'h300, 4'b1100, 32'hABCDABCD, 32'h00000080, 2);
    // SB lane 1, byte replicated.
    do_acc(1, 0, 3'b000, 32'h101, 32'h000000EE, 2, 32'h0, 32'h100, 4'b0010, 32'hEEEEEEEE, 32'h00000080, 4);
    // LH / LHU from the upper half.
    do_acc(0, 1, 3'b001, 32'h206, 32'h0, 0, 32'h80017FFF, 32'h204, 4'b1100, 32'h0, 32'hFFFF8001, 2);
    do_acc(0, 1, 3'b101, 32'h206, 32'h0, 1, 32'h80017FFF, 32'h204, 4'b1100, 32'h0, 32'h00008001, 3);
    // Both request lines high: store wins, load_data unchanged.
    do_acc(1, 1, 3'b010, 32'h500, 32'hCAFEF00D, 0, 32'h11111111, 32'h500, 4'b1111, 32'hCAFEF00D, 32'h00008001, 2);

    // Illegal funct3 encodings.
    do_fault(0, 1, 3'b011, 32'h100);
    do_fault(0, 1, 3'b110, 32'h100);
    do_fault(1, 0, 3'b100, 32'h100);
    do_fault(1, 0, 3'b111, 32'h100);

    // Stray ack while idle must not load anything.
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("lit_idle_ack", load_data, 32'h00008001);

    // Reset in the 2nd REQ cycle abandons the load.
    MemW_in    = 1'b0;
    memRead_in = 1'b1;
    funct3_in  = 3'b010;
    addr_in    = 32'h700;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("lit_midreq_req", dmem_req, 1'b0);
    check("lit_midreq_stall", stall, 1'b0);
    check("lit_midreq_load", load_data, 32'h0);
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    // First access right after release.
    do_acc(0, 1, 3'b010, 32'h600, 32'h0, 0, 32'hA5A5A5A5, 32'h600, 4'b1111, 32'h0, 32'hA5A5A5A5, 2);

`ifdef MISALIGN_TRAP_EN
    do_fault(0, 1, 3'b010, 32'h401);
    do_fault(1, 0, 3'b001, 32'h303);
`else
    // Misaligned accesses forced to natural alignment.
    do_acc(0, 1, 3'b010, 32'h401, 32'h0, 0, 32'h12345678, 32'h400, 4'b1111, 32'h0, 32'h12345678, 2);
    do_acc(1, 0, 3'b001, 32'h303, 32'h00005555, 0, 32'h0, 32'h300, 4'b1100, 32'h55555555, 32'h12345678, 2);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
